// File: rtl/mem_pkg.sv
// Shared types and helpers for the single-port byte-enable memory with init engine.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  function automatic int byte_count(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-deep shift register carrying read valid/data/err from the accept edge to the outputs.
module mem_rd_pipe #(
  parameter int WIDTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_err_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_err_o
);

  logic [RD_LAT-1:0]            valid_q, valid_d;
  logic [RD_LAT-1:0]            err_q, err_d;
  logic [RD_LAT-1:0][WIDTH-1:0] data_q, data_d;

  // Data is zeroed on empty slots so rdata_o reads 0 whenever rvalid_o is low.
  always_comb begin
    valid_d    = '0;
    err_d      = '0;
    data_d     = '0;
    valid_d[0] = in_valid_i;
    err_d[0]   = in_valid_i & in_err_i;
    data_d[0]  = in_valid_i ? in_data_i : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[RD_LAT-1];
  assign out_err_o   = err_q[RD_LAT-1];
  assign out_data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_sp_be_init.sv
// Single-port synchronous memory with byte strobes, pipelined reads, range errors
// and a sweep engine that fills the array with INIT_VAL.
module mem_sp_be_init
  import mem_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 64,
  parameter int               ADDR_WIDTH  = $clog2(DEPTH),
  parameter int               RD_LAT      = 1,
  parameter logic [WIDTH-1:0] INIT_VAL    = '0,
  parameter bit               INIT_ON_RST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     wr_rd_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [WIDTH/8-1:0]       wstrb_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     rvalid_o,
  output logic                     err_o,
  input  logic                     init_i,
  output logic                     busy_o,
  output state_e                   dbg_state_o
);

  localparam int NBYTES = byte_count(WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_sp_be_init: RD_LAT must be 1 or 2");
  end
  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("mem_sp_be_init: WIDTH must be a multiple of 8");
  end

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic                  init_we;
  logic                  in_range;
  logic                  accept;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [WIDTH-1:0]      rd_data;
  logic                  pipe_err;

  // Addresses can only exceed DEPTH when DEPTH is not a power of two.
  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (addr_i < ADDR_WIDTH'(DEPTH));
  end

  // Handshake: a request transfers on a rising edge where valid_i && ready_o;
  // ready_o is high only in IDLE and drops combinationally while init_i is high.
  assign accept  = valid_i && ready_o;
  assign wr_fire = accept && wr_rd_i && in_range;
  assign rd_fire = accept && !wr_rd_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    ready_o = 1'b0;
    init_we = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        state_d = INIT_ON_RST ? ST_INIT : ST_IDLE;
        cnt_d   = '0;
      end
      ST_INIT: begin
        busy_o  = 1'b1;
        init_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        ready_o = !init_i;
        if (init_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    wr_err_d = accept && wr_rd_i && !in_range;
    rd_data  = '0;
    if (in_range) begin
      rd_data = mem[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  // The array has no reset so a backdoor preload survives reset when INIT_ON_RST=0.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (wr_fire) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wstrb_i[k]) begin
          mem[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  mem_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (rd_fire),
    .in_data_i   (rd_data),
    .in_err_i    (!in_range),
    .out_valid_o (rvalid_o),
    .out_data_o  (rdata_o),
    .out_err_o   (pipe_err)
  );

  assign err_o       = wr_err_q | pipe_err;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_sp_be_init.sv
// Bench for mem_sp_be_init: a 64-word RD_LAT=1 instance with init on reset and a
// 48-word RD_LAT=2 instance without, checked against an array model and expected queues.
module tb_mem_sp_be_init;

  localparam logic [15:0] INIT_A = 16'hA5A5;
  localparam logic [15:0] INIT_B = 16'h5A3C;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        va, wa, ia, vb, wb, ib;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [1:0]  strb_a, strb_b;
  logic        ready_a, rvalid_a, err_a, busy_a;
  logic        ready_b, rvalid_b, err_b, busy_b;
  mem_pkg::state_e st_a, st_b;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          err_q[$];
  logic [15:0] model_a [64];
  logic [15:0] model_b [48];
  int          cur = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  mem_sp_be_init #(
    .WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6), .RD_LAT(1), .INIT_VAL(INIT_A), .INIT_ON_RST(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_n), .valid_i(va), .wr_rd_i(wa), .addr_i(addr_a),
    .wdata_i(wdata_a), .wstrb_i(strb_a), .ready_o(ready_a), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .err_o(err_a), .init_i(ia), .busy_o(busy_a), .dbg_state_o(st_a)
  );

  mem_sp_be_init #(
    .WIDTH(16), .DEPTH(48), .ADDR_WIDTH(6), .RD_LAT(2), .INIT_VAL(INIT_B), .INIT_ON_RST(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_n), .valid_i(vb), .wr_rd_i(wb), .addr_i(addr_b),
    .wdata_i(wdata_b), .wstrb_i(strb_b), .ready_o(ready_b), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .err_o(err_b), .init_i(ib), .busy_o(busy_b), .dbg_state_o(st_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] mask;
    mask = {{8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic w, input int addr,
                       input logic [15:0] d, input logic [1:0] s, input logic i);
    logic [5:0] a6;
    a6 = addr[5:0];
    if (sel == 0) begin
      va = v; wa = w; addr_a = a6; wdata_a = d; strb_a = s; ia = i;
    end else begin
      vb = v; wb = w; addr_b = a6; wdata_b = d; strb_b = s; ib = i;
    end
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b0);
  endtask

  // Apply the accepted request to the model; the accept edge is the next posedge.
  task automatic record(input int sel, input logic wr, input int addr,
                        input logic [15:0] d, input logic [1:0] s);
    int n, depth, lat;
    rd_exp_t e;
    n     = cyc + 1;
    depth = (sel == 0) ? 64 : 48;
    lat   = (sel == 0) ? 1 : 2;
    if (wr) begin
      if (addr < depth) begin
        if (sel == 0) model_a[addr] = merge(model_a[addr], d, s);
        else          model_b[addr] = merge(model_b[addr], d, s);
      end else begin
        err_q.push_back(n);
      end
    end else begin
      e.due  = n + lat - 1;
      e.err  = (addr >= depth);
      e.data = 16'h0;
      if (!e.err) e.data = (sel == 0) ? model_a[addr] : model_b[addr];
      exp_q.push_back(e);
      if (e.err) err_q.push_back(e.due);
    end
  endtask

  // Called at a negedge; leaves the request asserted so calls can run back-to-back.
  task automatic issue(input int sel, input logic wr, input int addr,
                       input logic [15:0] d, input logic [1:0] s);
    drive(sel, 1'b1, wr, addr, d, s, 1'b0);
    #1;
    for (int i = 0; i < 300 && !rdy(sel); i++) begin
      @(negedge clk);
      #1;
    end
    check("ready_wait", rdy(sel), 1'b1);
    if (rdy(sel)) record(sel, wr, addr, d, s);
    @(negedge clk);
  endtask

  task automatic count_busy(input int sel, output int cnt);
    int bad;
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy(sel)) begin
        cnt++;
        if (rdy(sel)) bad++;
      end else if (cnt > 0) begin
        break;
      end
      @(negedge clk);
    end
    check("ready_during_init", bad, 0);
  endtask

  // init_i raised together with a write to addr 3; the write must be dropped.
  task automatic do_init(input int sel);
    int cnt;
    drive(sel, 1'b1, 1'b1, 3, 16'hBEEF, 2'b11, 1'b1);
    #1;
    check("ready_forced_low", rdy(sel), 1'b0);
    @(negedge clk);
    idle(sel);
    check("busy_after_init", busy(sel), 1'b1);
    count_busy(sel, cnt);
    check("init_busy_cycles", cnt, (sel == 0) ? 64 : 48);
    if (sel == 0) foreach (model_a[i]) model_a[i] = INIT_A;
    else          foreach (model_b[i]) model_b[i] = INIT_B;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() > 0 || err_q.size() > 0); i++) @(negedge clk);
    check("drain_rd", exp_q.size(), 0);
    check("drain_err", err_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready_a", ready_a, 1'b0);   check("rst_ready_b", ready_b, 1'b0);
    check("rst_rvalid_a", rvalid_a, 1'b0); check("rst_rvalid_b", rvalid_b, 1'b0);
    check("rst_err_a", err_a, 1'b0);       check("rst_err_b", err_b, 1'b0);
    check("rst_rdata_a", rdata_a, 16'h0);  check("rst_rdata_b", rdata_b, 16'h0);
    check("rst_busy_a", busy_a, 1'b0);     check("rst_busy_b", busy_b, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic        ov, oe, xv, xe, othr;
    logic [15:0] od;
    if (rst_n) begin
      ov   = (cur == 0) ? rvalid_a : rvalid_b;
      oe   = (cur == 0) ? err_a : err_b;
      od   = (cur == 0) ? rdata_a : rdata_b;
      othr = (cur == 0) ? (rvalid_b | err_b) : (rvalid_a | err_a);
      xv   = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (xv || ov) check("rvalid", ov, xv);
      if (xv && ov) check("rdata", od, exp_q[0].data);
      if (xv) void'(exp_q.pop_front());
      xe = 1'b0;
      while (err_q.size() > 0 && err_q[0] == cyc) begin
        xe = 1'b1;
        void'(err_q.pop_front());
      end
      if (xe || oe) check("err", oe, xe);
      check("idle_dut_quiet", othr, 1'b0);
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    int addr;
    idle(0);
    idle(1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Init sweep after reset on A; B goes straight to IDLE.
    count_busy(0, cnt);
    check("rst_init_busy_cycles", cnt, 64);
    check("state_a_idle", st_a, mem_pkg::ST_IDLE);
    check("busy_b_never", busy_b, 1'b0);
    check("ready_b_idle", ready_b, 1'b1);
    foreach (model_a[i]) model_a[i] = INIT_A;

    cur = 0;
    for (int i = 0; i < 64; i++) issue(0, 1'b0, i, 16'h0, 2'b00);
    issue(0, 1'b1, 5, 16'h1234, 2'b11);
    issue(0, 1'b1, 5, 16'hFFFF, 2'b01);
    issue(0, 1'b0, 5, 16'h0, 2'b00);
    issue(0, 1'b1, 9, 16'h7777, 2'b00);
    issue(0, 1'b0, 9, 16'h0, 2'b00);
    idle(0);
    @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(0);
        @(negedge clk);
      end
      issue(0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    // A read still in flight when init is requested returns pre-init data.
    issue(0, 1'b1, 7, 16'hC0DE, 2'b11);
    issue(0, 1'b0, 7, 16'h0, 2'b00);
    do_init(0);
    issue(0, 1'b0, 3, 16'h0, 2'b00);
    issue(0, 1'b0, 7, 16'h0, 2'b00);
    idle(0);
    drain();

    // Instance B: fill, burst readback, out-of-range, random traffic, backdoor dump.
    cur = 1;
    for (int i = 0; i < 48; i++) issue(1, 1'b1, i, 16'($urandom), 2'b11);
    for (int i = 0; i < 48; i++) issue(1, 1'b0, i, 16'h0, 2'b00);
    issue(1, 1'b1, 50, 16'hDEAD, 2'b11);
    issue(1, 1'b0, 50, 16'h0, 2'b00);
    issue(1, 1'b0, 47, 16'h0, 2'b00);
    issue(1, 1'b0, 48, 16'h0, 2'b00);
    issue(1, 1'b1, 63, 16'h0BAD, 2'b01);
    idle(1);
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
        @(negedge clk);
      end
      issue(1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    idle(1);
    drain();
    for (int i = 0; i < 48; i++) check("dump_b", dut_b.mem[i], model_b[i]);
    issue(1, 1'b0, 11, 16'h0, 2'b00);
    do_init(1);
    for (int i = 0; i < 4; i++) begin
      addr = $urandom_range(0, 47);
      issue(1, 1'b1, addr, 16'($urandom), 2'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 48; i += 5) issue(1, 1'b0, i, 16'h0, 2'b00);
    idle(1);
    drain();

    // Reset in the middle of an init sweep on A.
    cur = 0;
    drive(0, 1'b0, 1'b0, 0, 16'h0, 2'b00, 1'b1);
    @(negedge clk);
    idle(0);
    repeat (10) @(negedge clk);
    check("mid_init_state", st_a, mem_pkg::ST_INIT);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    err_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(0, cnt);
    check("reinit_busy_cycles", cnt, 64);
    for (int i = 0; i < 64; i += 9) issue(0, 1'b0, i, 16'h0, 2'b00);
    idle(0);
    drain();
    cur = 1;
    for (int i = 0; i < 48; i += 7) issue(1, 1'b0, i, 16'h0, 2'b00);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sp_be_init.md
Name: mem_sp_be_init

Overview:
- Parametrised single-port synchronous memory, successor to the basic valid/ready memory model.
- Adds per-byte write strobes, a configurable pipelined read latency and out-of-range error reporting.
- Adds a hardware init engine that fills the array with INIT_VAL after reset or on request.
- Used as the on-chip scratch/data store behind bus adapters; the storage array stays backdoor-accessible for preload and dump in testbenches.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles from accept to rvalid_o; legal values 1 or 2.
- INIT_VAL, 0, WIDTH-bit fill value written by the init engine.
- INIT_ON_RST, 1, 1 = run init after reset release; 0 = go straight to IDLE so backdoor preload is preserved.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- wr_rd_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  WIDTH  write data.
- wstrb_i  in  WIDTH/8  byte write enables; bit k covers wdata_i[8k+7:8k].
- ready_o  out  1  request accepted on a cycle where valid_i && ready_o.
- rdata_o  out  WIDTH  read data; meaningful only while rvalid_o=1.
- rvalid_o  out  1  one-cycle pulse per accepted read.
- err_o  out  1  one-cycle pulse, aligned with write accept or with rvalid_o, when addr_i >= DEPTH.
- init_i  in  1  single-cycle request to re-run the init engine.
- busy_o  out  1  init engine active.

Behaviour:
- Reset (rst_i=0, async): ready_o=0, rvalid_o=0, err_o=0, rdata_o=0, busy_o=0, init counter=0, read pipeline cleared. The array is not reset.
- Storage is a single unpacked array named mem[0:DEPTH-1] so hierarchical $readmemh/$writememh on dut.mem works.
- FSM states:
  - INIT: busy_o=1, ready_o=0; writes INIT_VAL to mem[cnt] each cycle, cnt 0..DEPTH-1; after writing DEPTH-1 -> IDLE.
  - IDLE: busy_o=0, ready_o=1.
- After reset release: INIT if INIT_ON_RST=1, otherwise IDLE. The first transition is taken on the first clk_i edge with rst_i=1.
- IDLE + init_i=1 -> INIT with cnt=0.
  - init_i has priority over a simultaneous valid_i; that request is not accepted (ready_o was 1, so the master must see ready_o drop next cycle and the request is dropped).
  - Specified rule: in that cycle ready_o is forced to 0 combinationally when init_i=1.
  - init_i while in INIT is ignored; the sweep is not restarted.
- Write accept (valid_i && ready_o && wr_rd_i):
  - For each k with wstrb_i[k]=1, update byte k of mem[addr_i] at that edge.
  - wstrb_i=0 is a legal no-op.
  - Back-to-back writes are allowed every cycle.
- Read accept (valid_i && ready_o && !wr_rd_i):
  - Array is sampled at the accept edge.
  - RD_LAT=1: rdata_o/rvalid_o are valid in the cycle after accept.
  - RD_LAT=2: one extra output register stage.
  - Fully pipelined: a read every cycle yields rvalid_o every cycle, in order.
- Write then read to the same address on consecutive cycles returns the new data. Write and read cannot share a cycle (single port).
- Out of range (addr_i >= DEPTH, only possible when DEPTH is not 2^ADDR_WIDTH):
  - Writes are dropped; err_o pulses the cycle after accept.
  - Reads return rdata_o=0 with rvalid_o=1 and err_o=1 aligned.
- In-flight reads at an init request still complete with pre-init data; the pipeline drains independently of the FSM.
- Reset mid-INIT leaves the array partially filled; the sweep restarts from 0 if INIT_ON_RST=1.
- rvalid_o/err_o are never asserted without a corresponding accept.

Decomposition:
- Package mem_pkg: FSM state enum (ST_INIT, ST_IDLE), the RD_LAT legal-value check constant, and a byte-count helper (WIDTH/8).
- One sub-module: mem_rd_pipe, an RD_LAT-deep valid/data/err shift register carrying read results; the array and FSM stay in the top.

Test Plan:
- INIT_ON_RST=1, INIT_VAL=16'hA5A5: release reset -> busy_o=1 for exactly 64 cycles, ready_o=0 throughout, then all 64 reads return 16'hA5A5.
- INIT_ON_RST=0: $readmemh preload, then read addr 0..63 -> rdata_o matches file; $writememh dump after 64 random frontdoor writes matches the scoreboard.
- Write 16'h1234 strobe 2'b11 to addr 5, then 16'hFFFF strobe 2'b01 -> read addr 5 returns 16'h12FF one cycle (RD_LAT=1) or two cycles (RD_LAT=2) after accept.
- 10 back-to-back reads with RD_LAT=2 -> 10 consecutive rvalid_o pulses starting 2 cycles after the first accept, in address order.
- DEPTH=48, ADDR_WIDTH=6: write to addr 50 -> err_o pulse, mem unchanged; read addr 50 -> rdata_o=0, rvalid_o=1, err_o=1.
- init_i asserted with valid_i (write addr 3) in IDLE -> write dropped, busy_o=1 for DEPTH cycles, addr 3 reads INIT_VAL; reset asserted mid-INIT -> all outputs 0 immediately.
